// File: rtl/mac_header_insert.sv
// rtl/mac_header_insert.sv - prepends a 14-byte Ethernet II header (DA, SA, EtherType) to a payload stream.
// DA/EtherType arrive on tuser of the first beat; SA comes from the per-ID config register.
module mac_header_insert #(
  parameter int AXIS_BUS_WIDTH  = 64,
  parameter int AXIS_ID_WIDTH   = 4,
  parameter int AXIS_DEST_WIDTH = 0,
  localparam int EFF_ID   = (AXIS_ID_WIDTH   > 0) ? AXIS_ID_WIDTH   : 1,
  localparam int EFF_DEST = (AXIS_DEST_WIDTH > 0) ? AXIS_DEST_WIDTH : 1
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic [AXIS_BUS_WIDTH-1:0]     axis_in_tdata,
  input  logic [63:0]                   axis_in_tuser,
  input  logic [EFF_ID-1:0]             axis_in_tid,
  input  logic [EFF_DEST-1:0]           axis_in_tdest,
  input  logic [AXIS_BUS_WIDTH/8-1:0]   axis_in_tkeep,
  input  logic                          axis_in_tlast,
  input  logic                          axis_in_tvalid,
  output logic                          axis_in_tready,
  output logic [AXIS_BUS_WIDTH-1:0]     axis_out_tdata,
  output logic [EFF_ID-1:0]             axis_out_tid,
  output logic [EFF_DEST-1:0]           axis_out_tdest,
  output logic [AXIS_BUS_WIDTH/8-1:0]   axis_out_tkeep,
  output logic                          axis_out_tlast,
  output logic                          axis_out_tvalid,
  input  logic                          axis_out_tready,
  output logic [EFF_ID+EFF_DEST-1:0]    mac_config_sel,
  input  logic [47:0]                   mac_config_regs
);

  generate
    if (AXIS_BUS_WIDTH != 64) begin : g_bad_width
      $error("mac_header_insert supports only AXIS_BUS_WIDTH = 64");
    end
  endgenerate

  typedef enum logic [1:0] {HDR0, HDR1, BODY, TAIL} state_t;

  state_t               state;
  state_t               state_nxt;
  logic                 slot_free;
  logic                 in_ready;
  logic                 accept;
  logic                 tail_needed;
  logic [63:0]          in_m;

  logic                 ld;
  logic [63:0]          ld_data;
  logic [7:0]           ld_keep;
  logic                 ld_last;
  logic [EFF_ID-1:0]    ld_tid;
  logic [EFF_DEST-1:0]  ld_tdest;

  logic [31:0]          sa_lo;
  logic [15:0]          et;
  logic [47:0]          res_data;
  logic [5:0]           res_keep;
  logic [EFF_ID-1:0]    id_q;
  logic [EFF_DEST-1:0]  dest_q;

  assign mac_config_sel = {axis_in_tid, axis_in_tdest};
  assign slot_free      = !axis_out_tvalid || axis_out_tready;
  assign in_ready       = ((state == HDR1) || (state == BODY)) && slot_free;
  assign axis_in_tready = in_ready;
  assign accept         = in_ready && axis_in_tvalid;
  // Any valid byte past lane 1 spills into an extra TAIL beat.
  assign tail_needed    = |axis_in_tkeep[7:2];

  // Invalid input lanes are zeroed so disabled output bytes read as 0.
  always_comb begin
    in_m = '0;
    for (int i = 0; i < 8; i++) begin
      in_m[8*i +: 8] = axis_in_tdata[8*i +: 8] & {8{axis_in_tkeep[i]}};
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state <= HDR0;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      HDR0: if (axis_in_tvalid && slot_free) state_nxt = HDR1;
      HDR1, BODY: begin
        if (accept) begin
          if (!axis_in_tlast)   state_nxt = BODY;
          else if (tail_needed) state_nxt = TAIL;
          else                  state_nxt = HDR0;
        end
      end
      TAIL: if (slot_free) state_nxt = HDR0;
      default: state_nxt = HDR0;
    endcase
  end

  always_comb begin
    ld       = 1'b0;
    ld_data  = '0;
    ld_keep  = '0;
    ld_last  = 1'b0;
    ld_tid   = id_q;
    ld_tdest = dest_q;
    unique case (state)
      HDR0: begin
        // Header beat is built from the peeked first beat; lane 0 carries the field MSB.
        ld       = axis_in_tvalid && slot_free;
        ld_data  = {mac_config_regs[39:32], mac_config_regs[47:40],
                    axis_in_tuser[7:0],   axis_in_tuser[15:8],  axis_in_tuser[23:16],
                    axis_in_tuser[31:24], axis_in_tuser[39:32], axis_in_tuser[47:40]};
        ld_keep  = 8'hFF;
        ld_tid   = axis_in_tid;
        ld_tdest = axis_in_tdest;
      end
      HDR1: begin
        ld      = accept;
        ld_data = {in_m[15:8], in_m[7:0], et[7:0], et[15:8],
                   sa_lo[7:0], sa_lo[15:8], sa_lo[23:16], sa_lo[31:24]};
        ld_keep = {axis_in_tkeep[1:0], 6'h3F};
        ld_last = axis_in_tlast && !tail_needed;
      end
      BODY: begin
        ld      = accept;
        ld_data = {in_m[15:0], res_data};
        ld_keep = {axis_in_tkeep[1:0], 6'h3F};
        ld_last = axis_in_tlast && !tail_needed;
      end
      TAIL: begin
        ld      = slot_free;
        ld_data = {16'h0000, res_data};
        ld_keep = {2'b00, res_keep};
        ld_last = 1'b1;
      end
      default: ld = 1'b0;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      sa_lo    <= '0;
      et       <= '0;
      id_q     <= '0;
      dest_q   <= '0;
      res_data <= '0;
      res_keep <= '0;
    end else begin
      if ((state == HDR0) && ld) begin
        sa_lo  <= mac_config_regs[31:0];
        et     <= axis_in_tuser[63:48];
        id_q   <= axis_in_tid;
        dest_q <= axis_in_tdest;
      end
      if (accept) begin
        res_data <= in_m[63:16];
        res_keep <= axis_in_tkeep[7:2];
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      axis_out_tvalid <= 1'b0;
      axis_out_tdata  <= '0;
      axis_out_tkeep  <= '0;
      axis_out_tlast  <= 1'b0;
      axis_out_tid    <= '0;
      axis_out_tdest  <= '0;
    end else if (slot_free) begin
      axis_out_tvalid <= ld;
      if (ld) begin
        axis_out_tdata  <= ld_data;
        axis_out_tkeep  <= ld_keep;
        axis_out_tlast  <= ld_last;
        axis_out_tid    <= ld_tid;
        axis_out_tdest  <= ld_tdest;
      end
    end
  end

endmodule
